// File: rtl/spi_fetch.sv
// SPI flash read sequencer: drives the SPI controller register port to issue a read command,
// a 24-bit address and up to 8 data bytes. Define SPI_FETCH_FAST_READ_EN for fast read (0x0B + dummy byte).
module spi_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [2:0]  req_len,
  input  logic [1:0]  req_sel,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        rd_last,
  output logic        busy,
  output logic [2:0]  spi_reg_addr,
  output logic [7:0]  spi_reg_wdata,
  output logic [1:0]  spi_reg_sel,
  output logic        spi_reg_write,
  output logic        spi_reg_read,
  input  logic [7:0]  spi_reg_rdata,
  input  logic        spi_interrupt
);

`ifdef SPI_FETCH_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WAIT, S_ADDR, S_DUMMY, S_DATA, S_RDBYTE, S_END
  } state_t;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WAIT, S_ADDR, S_DATA, S_RDBYTE, S_END
  } state_t;
`endif

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [23:0] addr_q, addr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  phase_q, phase_d;
  logic        first_q, first_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_last_q, rd_last_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      phase_q    <= '0;
      first_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      phase_q    <= phase_d;
      first_q    <= first_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Ready is held off during the rd_last pulse so back-to-back fetches start one cycle later.
  assign req_ready   = (state_q == S_IDLE) && !rd_last_q;
  assign busy        = (state_q != S_IDLE);
  assign spi_reg_sel = busy ? sel_q : 2'd0;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_last     = rd_last_q;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    phase_d       = phase_q;
    first_d       = 1'b0;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    rd_last_d     = 1'b0;
    spi_reg_write = 1'b0;
    spi_reg_read  = 1'b0;
    spi_reg_addr  = 3'd0;
    spi_reg_wdata = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (req && req_ready) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          sel_d   = req_sel;
          phase_d = 2'd0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        spi_reg_write = 1'b1;
        spi_reg_wdata = CMD_BYTE;
        ret_d         = S_CMD;
        first_d       = 1'b1;
        state_d       = S_WAIT;
      end
      S_ADDR: begin
        spi_reg_write = 1'b1;
        spi_reg_addr  = 3'd1;
        case (phase_q)
          2'd0:    spi_reg_wdata = addr_q[23:16];
          2'd1:    spi_reg_wdata = addr_q[15:8];
          default: spi_reg_wdata = addr_q[7:0];
        endcase
        phase_d = phase_q + 2'd1;
        ret_d   = S_ADDR;
        first_d = 1'b1;
        state_d = S_WAIT;
      end
`ifdef SPI_FETCH_FAST_READ_EN
      S_DUMMY: begin
        spi_reg_write = 1'b1;
        spi_reg_addr  = 3'd1;
        ret_d         = S_DUMMY;
        first_d       = 1'b1;
        state_d       = S_WAIT;
      end
`endif
      S_DATA: begin
        spi_reg_write = 1'b1;
        spi_reg_addr  = 3'd1;
        ret_d         = S_DATA;
        first_d       = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        // The interrupt flag is registered in the controller, so the first WAIT cycle sees a stale value.
        if (!first_q && spi_interrupt) begin
          case (ret_q)
            S_CMD:  state_d = S_ADDR;
`ifdef SPI_FETCH_FAST_READ_EN
            S_ADDR:  state_d = (phase_q == 2'd3) ? S_DUMMY : S_ADDR;
            S_DUMMY: state_d = S_DATA;
`else
            S_ADDR:  state_d = (phase_q == 2'd3) ? S_DATA : S_ADDR;
`endif
            default: state_d = (cnt_q == 3'd0) ? S_END : S_RDBYTE;
          endcase
        end
      end
      S_RDBYTE: begin
        spi_reg_read = 1'b1;
        spi_reg_addr = 3'd1;
        rd_data_d    = spi_reg_rdata;
        rd_valid_d   = 1'b1;
        cnt_d        = cnt_q - 3'd1;
        state_d      = S_DATA;
      end
      S_END: begin
        spi_reg_read = 1'b1;
        rd_data_d    = spi_reg_rdata;
        rd_valid_d   = 1'b1;
        rd_last_d    = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
